sr_muldiv_seq: RTL and testbench

- Parametrised, iterative unsigned multiply/divide unit for schoolRISCV.
- Successor to the single-cycle combinational ALU multiply: it adds MULHU, DIVU and REMU, and computes one bit per clock instead of using a full-width combinational array.
- Sits beside sr_alu in the execute stage.
- The core stalls on valid/ready handshakes on both the request side and the response side.

---
 rtl/sr_muldiv_seq.sv | 170 +++++++++++++++++
 tb/tb_sr_muldiv_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit for schoolRISCV, one result bit per clock.
// Define SR_MULDIV_EARLY_OUT_EN to let multiplies finish as soon as the multiplier runs out.
module sr_muldiv_seq #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   oper,
    input  logic [W-1:0] srcA,
    input  logic [W-1:0] srcB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         div_zero
);

    localparam logic [1:0] OpMul   = 2'b00;
    localparam logic [1:0] OpMulhu = 2'b01;
    localparam logic [1:0] OpDivu  = 2'b10;
    localparam logic [1:0] OpRemu  = 2'b11;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    // hi: product upper half or partial remainder; lo: multiplier or dividend/quotient;
    // b: multiplicand or divisor.
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     res_q, res_d;
    logic             dz_q, dz_d;

    logic [W:0]       mul_sum;
    logic [W-1:0]     mul_hi, mul_lo;
    logic [W:0]       rem_sh, rem_sub;
    logic             div_ge;
    logic [W-1:0]     div_hi, div_lo;
    logic [W-1:0]     fin_res;

    // Shift-add step: carry out of the add becomes the new top bit after the shift.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign mul_hi  = mul_sum[W:1];
    assign mul_lo  = {mul_sum[0], lo_q[W-1:1]};

    // Restoring division step on a W+1-bit shifted remainder.
    assign rem_sh  = {hi_q, lo_q[W-1]};
    assign div_ge  = (rem_sh >= {1'b0, b_q});
    assign rem_sub = div_ge ? (rem_sh - {1'b0, b_q}) : rem_sh;
    assign div_hi  = rem_sub[W-1:0];
    assign div_lo  = {lo_q[W-2:0], div_ge};

    always_comb begin
        fin_res = div_hi;
        unique case (op_q)
            OpMul:   fin_res = mul_lo;
            OpMulhu: fin_res = mul_hi;
            OpDivu:  fin_res = div_lo;
            OpRemu:  fin_res = div_hi;
            default: fin_res = div_hi;
        endcase
    end

`ifdef SR_MULDIV_EARLY_OUT_EN
    logic [W-1:0]     mlt_mask;
    logic             early;
    logic [CNT_W-1:0] sh_amt;
    logic [2*W-1:0]   aligned;

    // After cnt_q steps the unconsumed multiplier bits sit in lo_q[W-1-cnt_q:0].
    assign mlt_mask = {W{1'b1}} >> cnt_q;
    assign early    = ~op_q[1] && ((lo_q & mlt_mask) == '0);
    assign sh_amt   = CNT_W'(W) - cnt_q;
    assign aligned  = {hi_q, lo_q} >> sh_amt;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        res_d     = res_q;
        dz_d      = dz_q;
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d  = oper;
                    cnt_d = '0;
                    hi_d  = '0;
                    if (oper[1]) begin
                        b_d  = srcB;
                        lo_d = srcA;
                    end else begin
                        b_d  = srcA;
                        lo_d = srcB;
                    end
                    if (oper[1] && (srcB == '0)) begin
                        res_d   = (oper == OpRemu) ? srcA : {W{1'b1}};
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q[1]) begin
                    hi_d = div_hi;
                    lo_d = div_lo;
                end else begin
                    hi_d = mul_hi;
                    lo_d = mul_lo;
                end
                if (cnt_q == CNT_W'(W - 1)) begin
                    res_d   = fin_res;
                    state_d = StDone;
                end
`ifdef SR_MULDIV_EARLY_OUT_EN
                if (early) begin
                    res_d   = (op_q == OpMul) ? aligned[W-1:0] : aligned[2*W-1:W];
                    state_d = StDone;
                end
`endif
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
        end
    end

    assign result   = res_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_sr_muldiv_seq.sv
// Scoreboard bench for sr_muldiv_seq: driver pushes model results, monitor pops on out_valid.
`timescale 1ns/1ps
module tb_sr_muldiv_seq;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   oper;
    logic [W-1:0] srcA;
    logic [W-1:0] srcB;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         div_zero;

    sr_muldiv_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .oper      (oper),
        .srcA      (srcA),
        .srcB      (srcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         dz;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   stall_n  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic and RISC-V divide-by-zero rules.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t           e;
        logic [2*W-1:0] p;
        int             blen;
        p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.dz  = 1'b0;
        e.lat = W + 1;
        e.acc = 0;
        case (op)
            2'd0: e.res = p[W-1:0];
            2'd1: e.res = p[2*W-1:W];
            2'd2: begin
                if (b == 0) begin e.res = {W{1'b1}}; e.dz = 1'b1; e.lat = 1; end
                else e.res = a / b;
            end
            default: begin
                if (b == 0) begin e.res = a; e.dz = 1'b1; e.lat = 1; end
                else e.res = a % b;
            end
        endcase
`ifdef SR_MULDIV_EARLY_OUT_EN
        // Multiplies finish once the multiplier's remaining high bits are all zero.
        if (!op[1]) begin
            blen = 0;
            for (int i = 0; i < W; i++) if (b[i]) blen = i + 1;
            if (blen + 2 < int'(W) + 1) e.lat = blen + 2;
        end
`else
        blen = 0;
`endif
        return e;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit track);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles", n);
            return;
        end
        oper     = op;
        srcA     = a;
        srcB     = b;
        in_valid = 1'b1;
        e        = model(op, a, b);
        e.acc    = cyc;
        if (track) sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        oper     = 2'($urandom);
        srcA     = $urandom;
        srcB     = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || !in_ready) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results outstanding, in_ready %0b", sb.size(),
                     in_ready);
        end
    endtask

    // Monitor: owns out_ready, checks each presented result against the scoreboard.
    initial begin : monitor
        exp_t         e;
        logic [W-1:0] held;
        int           n;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got result %0h with no pending request",
                             result);
                    out_ready = 1'b1;
                    @(negedge clk);
                    out_ready = 1'b0;
                end else begin
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk("div_zero", div_zero, e.dz);
                    chk("latency", cyc - e.acc, e.lat);
                    chk("in_ready_done", in_ready, 1'b0);
                    held = result;
                    n    = stall_n;
                    for (int i = 0; i < n; i++) begin
                        @(negedge clk);
                        chk("held_valid", out_valid, 1'b1);
                        chk("held_result", result, held);
                        chk("held_in_ready", in_ready, 1'b0);
                    end
                    out_ready = 1'b1;
                    @(negedge clk);
                    out_ready = 1'b0;
                    chk("idle_out_valid", out_valid, 1'b0);
                    chk("idle_in_ready", in_ready, 1'b1);
                end
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int           r;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           n;
        rst      = 1'b1;
        in_valid = 1'b0;
        oper     = '0;
        srcA     = '0;
        srcB     = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, '0);
        chk("rst_div_zero", div_zero, 1'b0);
        rst = 1'b0;

        // Directed cases, including the divide-by-zero and width boundaries.
        issue(2'd0, 32'h0001_0000, 32'h0001_0000, 1'b1);
        issue(2'd1, 32'h0001_0000, 32'h0001_0000, 1'b1);
        issue(2'd2, 32'd100, 32'd7, 1'b1);
        issue(2'd3, 32'd100, 32'd7, 1'b1);
        issue(2'd2, 32'h1234_5678, 32'd0, 1'b1);
        issue(2'd3, 32'h1234_5678, 32'd0, 1'b1);
        issue(2'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(2'd0, 32'h1234_5678, 32'd0, 1'b1);
        issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(2'd2, 32'hDEAD_BEEF, 32'd1, 1'b1);
        issue(2'd3, 32'd5, 32'hFFFF_FFFF, 1'b1);
        drain();

        // Backpressure with ignored requests while the result is held.
        stall_n = 10;
        issue(2'd0, 32'd3, 32'd5, 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", out_valid, 1'b1);
        oper     = 2'd2;
        srcA     = 32'h55;
        srcB     = 32'd0;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        drain();
        stall_n = 0;

        // Reset in the middle of a multiply: no result, back to idle.
        issue(2'd0, $urandom, $urandom | 32'h8000_0000, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_result", result, '0);
        chk("abort_div_zero", div_zero, 1'b0);
        issue(2'd0, 32'd2, 32'd2, 1'b1);
        drain();

        // Randomised operations with mixed operand shapes and occasional stalls.
        for (int k = 0; k < 1000; k++) begin
            r = int'($urandom_range(0, 9));
            a = $urandom;
            if (r == 0)      b = '0;
            else if (r < 4)  b = W'($urandom_range(1, 255));
            else if (r == 4) b = W'(1);
            else if (r == 5) b = $urandom >> $urandom_range(0, 31);
            else             b = $urandom;
            if ($urandom_range(0, 7) == 0) a = a >> $urandom_range(0, 31);
            stall_n = int'($urandom_range(0, 2));
            issue(2'($urandom_range(0, 3)), a, b, 1'b1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
